uart_rx_monitor: RTL and testbench
==================================

Name: uart_rx_monitor

Overview:
- Synthesizable 8N1 UART receiver with a simulation console monitor.
- Watches the SoC's serial TX line, recovers bytes and presents them on a one-cycle valid strobe.
- Counts received bytes and flags framing errors.
- In simulation it also prints each received character, so firmware output is visible in the bench log.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUDRATE, 25000000, serial bit rate in baud.
- Derived: DIV = CLK_HZ/BAUDRATE (integer division) is the clocks per bit. DIV < 2 is a fatal elaboration error.

Ports:
- clk  input  1  system clock, rising-edge active.
- resetn  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last byte received; held until the next byte.
- rx_valid  output  1  one-cycle strobe when rx_data updates with a good byte.
- frame_error  output  1  one-cycle strobe when the stop bit is sampled low.
- rx_count  output  16  number of good bytes received; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; rx_data=0x00, rx_valid=0, frame_error=0, rx_count=0; both synchronizer flops =1.
- Input synchronizer: 2-flop, producing rx_s. All decisions use rx_s only.
- Frame format: start bit 0, 8 data bits LSB first, 1 stop bit 1. No parity.
- States: IDLE, START, DATA, STOP, BREAK.
- T0 reference: the first rising edge at which the FSM is in IDLE and sees rx_s=0. At T0 the FSM enters START with the bit counter loaded.
- START: at T0+DIV/2, sample rx_s.
  - rx_s=1: false start (glitch); return to IDLE, no outputs.
  - rx_s=0: enter DATA.
- DATA: bit k (k=0..7) is sampled at T0+DIV/2+(k+1)*DIV and shifted in LSB first.
- STOP: stop bit is sampled at T0+DIV/2+9*DIV.
  - rx_s=1: on that edge, rx_data <= assembled byte, rx_valid <= 1, rx_count <= rx_count+1; next state IDLE.
  - rx_s=0: frame_error <= 1; rx_data and rx_count unchanged; next state BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Strobes: rx_valid and frame_error are high for exactly one cycle, never simultaneously.
- Back-to-back frames: IDLE is re-entered on the stop-sample edge. A start bit immediately following a stop bit is detected with no lost byte.
- Latency for DIV=4: rx_valid is high during the cycle after edge T0+38. Including the synchronizer, that is about 40–41 clocks after the pin's falling edge.
- Reset mid-frame: abort immediately; no strobe; the partial byte is discarded.
- Simulation only (excluded from synthesis): on each rx_valid, write the character to the console with no newline added. On frame_error, print a warning with the simulation time.

Test Plan:
- Reset, then drive 0x55 at 25 Mbaud (4 clk/bit) -> single rx_valid pulse, rx_data=0x55, rx_count=1, frame_error never 1.
- Drive 0x00, then immediately 0xFF with no idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF, rx_count=2.
- Drive 'H','i','\n' (0x48,0x69,0x0A) -> rx_count=3, the last rx_data=0x0A, console shows "Hi".
- Pull uart_rx low for 1 clock only, then high -> no rx_valid, no frame_error, state back in IDLE, rx_count unchanged.
- Send 0xA5 with the stop bit forced 0, then hold the line low 20 clks, then idle -> one frame_error pulse, no rx_valid, rx_data unchanged, no further frames until the line returns high.
- Assert resetn low midway through bit 4 of 0x3C, release, then send 0xC3 -> no strobe for the aborted frame; then rx_data=0xC3, rx_count=1.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver that watches a serial TX line, recovers
// bytes, counts good frames and flags framing errors. Simulation builds also
// echo each received character to the console.
module uart_rx_monitor #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned BAUDRATE = 25000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_error,
    output logic [15:0] rx_count
);

    localparam int unsigned DIV    = CLK_HZ / BAUDRATE;
    localparam int unsigned HALF   = DIV / 2;
    localparam int unsigned CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT16_W = 16;

    // A divider below two leaves no mid-bit sample point.
    if (DIV < 2) begin : g_div_check
        $fatal(1, "uart_rx_monitor: CLK_HZ/BAUDRATE must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [DATA_W-1:0]    rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic [CNT16_W-1:0]   rx_count_q, rx_count_d;
    logic                 sample_c;

    // Bit-period counter reaching zero marks the mid-bit sample edge.
    assign sample_c = (cnt_q == '0);

    // State and datapath registers; synchronizer resets to the idle level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            rx_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            rx_count_q    <= rx_count_d;
        end
    end

    // Next-state logic; all decisions use the synchronized line only.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (sample_c) state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample_c && (bit_idx_q == BIT_W'(7))) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (sample_c) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output strobes for the current state.
    always_comb begin
        rx_meta_d     = uart_rx;
        rx_s_d        = rx_meta_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        rx_count_d    = rx_count_q;
        unique case (state_q)
            ST_IDLE: begin
                // Preload so the first sample lands mid start bit.
                cnt_d     = CNT_W'(HALF - 1);
                bit_idx_d = '0;
            end
            ST_START: begin
                cnt_d = sample_c ? CNT_W'(DIV - 1) : cnt_q - CNT_W'(1);
            end
            ST_DATA: begin
                if (sample_c) begin
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    cnt_d     = CNT_W'(DIV - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (sample_c) begin
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_count_d = rx_count_q + CNT16_W'(1);
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign rx_count    = rx_count_q;

`ifndef SYNTHESIS
    // Console echo of received characters and stop-bit warnings.
    always @(posedge clk) begin
        if (rx_valid_q) $write("%c", rx_data_q);
        if (frame_error_q) $display("uart_rx_monitor: warning, stop bit sampled low at %0t", $time);
    end
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: a reference model of the serial frames
// pushes expected {count, byte} pairs, and received strobes are matched in order.
module tb_uart_rx_monitor;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        uart_rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic [15:0] rx_count;

    uart_rx_monitor #(
        .CLK_HZ   (100000000),
        .BAUDRATE (25000000)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .rx_count    (rx_count)
    );

    always #5 clk = ~clk;

    // Observation side: record each good-byte strobe and pulse statistics.
    logic [23:0] obs_mem [32];
    int          obs_wr    = 0;
    int          valid_cnt = 0;
    int          ferr_cnt  = 0;
    int          both_cnt  = 0;
    int          long_cnt  = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            obs_mem[obs_wr[4:0]] <= {rx_count, rx_data};
            obs_wr    <= obs_wr + 1;
            valid_cnt <= valid_cnt + 1;
        end
        if (frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid === 1'b1 && frame_error === 1'b1) both_cnt <= both_cnt + 1;
        if (rx_valid === 1'b1 && prev_valid === 1'b1) long_cnt <= long_cnt + 1;
        prev_valid <= (rx_valid === 1'b1);
    end

    // Stimulus side state.
    logic [23:0] exp_q [$];
    logic [15:0] exp_count = '0;
    int          obs_rd = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(DIV);
        end
        uart_rx = stop;
        wait_clks(DIV);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_count = exp_count + 16'd1;
        exp_q.push_back({exp_count, b});
        send_frame(b, 1'b1);
    endtask

    // Match every recorded strobe against the scoreboard, in order.
    task automatic drain(input string tag);
        logic [23:0] e;
        check({tag, "_nframes"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
        while (obs_rd < obs_wr) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra"}, {8'h00, obs_mem[obs_rd[4:0]]}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check(tag, {8'h00, obs_mem[obs_rd[4:0]]}, {8'h00, e});
            end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    int v0;
    int f0;

    initial begin
        // Reset state
        #2 resetn = 1'b0;
        wait_clks(3);
        resetn = 1'b1;
        wait_clks(3);
        check("rst_data",  32'(rx_data),     32'h00);
        check("rst_valid", 32'(rx_valid),    32'h0);
        check("rst_ferr",  32'(frame_error), 32'h0);
        check("rst_count", 32'(rx_count),    32'h0);

        // Single byte
        send_good(8'h55);
        wait_clks(5);
        drain("b55");
        check("b55_ferr", 32'(ferr_cnt), 32'd0);

        // Back-to-back bytes with no idle gap
        send_good(8'h00);
        send_good(8'hFF);
        wait_clks(5);
        drain("b2b");
        check("b2b_count", 32'(rx_count), 32'(exp_count));

        // Text string
        send_good(8'h48);
        send_good(8'h69);
        send_good(8'h0A);
        wait_clks(5);
        drain("txt");
        check("txt_data", 32'(rx_data), 32'h0A);

        // One-clock glitch is rejected as a false start
        v0 = valid_cnt;
        uart_rx = 1'b0;
        wait_clks(1);
        uart_rx = 1'b1;
        wait_clks(12);
        check("glitch_valid", 32'(valid_cnt), 32'(v0));
        check("glitch_ferr",  32'(ferr_cnt),  32'd0);
        check("glitch_count", 32'(rx_count),  32'(exp_count));
        send_good(8'h5A);
        wait_clks(5);
        drain("post_glitch");

        // Stop bit low, line held low, then idle
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        wait_clks(20);
        check("brk_ferr",  32'(ferr_cnt),  32'(f0 + 1));
        check("brk_valid", 32'(valid_cnt), 32'(v0));
        check("brk_data",  32'(rx_data),   32'h5A);
        check("brk_count", 32'(rx_count),  32'(exp_count));
        uart_rx = 1'b1;
        wait_clks(20);
        check("brk_ferr_after",  32'(ferr_cnt),  32'(f0 + 1));
        check("brk_valid_after", 32'(valid_cnt), 32'(v0));
        drain("brk");
        send_good(8'h7E);
        wait_clks(5);
        drain("post_brk");

        // Reset midway through bit 4 of 0x3C
        v0 = valid_cnt;
        uart_rx = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(8'h3C >> i);
            wait_clks(DIV);
        end
        uart_rx = 1'b1;
        wait_clks(DIV / 2);
        resetn = 1'b0;
        wait_clks(2);
        check("abort_data",  32'(rx_data),  32'h00);
        check("abort_count", 32'(rx_count), 32'h0);
        resetn = 1'b1;
        wait_clks(45);
        check("abort_valid", 32'(valid_cnt), 32'(v0));
        exp_count = '0;
        send_good(8'hC3);
        wait_clks(5);
        drain("after_abort");
        check("after_abort_data",  32'(rx_data),  32'hC3);
        check("after_abort_count", 32'(rx_count), 32'h1);

        // Strobe shape over the whole run
        check("strobe_overlap", 32'(both_cnt), 32'd0);
        check("strobe_width",   32'(long_cnt), 32'd0);
        check("ferr_total",     32'(ferr_cnt), 32'd1);

        $display("");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
